// File: rtl/uart_tx_fifo_if.sv
// Host/UART-side signal bundle for uart_tx_fifo: push port, status flags and uart_ip launch handshake.
// The slave modport is the FIFO's view; the master modport is the host/uart_ip side.
interface uart_tx_fifo_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic              uart_en;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              flush;
    logic              full;
    logic              empty;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic              busy;
    logic              start_tx;
    logic [DATA_W-1:0] data_in;
    logic              tx_done;

    modport master (
        output uart_en, wr_en, wr_data, flush, tx_done,
        input  full, empty, count, overflow, busy, start_tx, data_in
    );

    modport slave (
        input  uart_en, wr_en, wr_data, flush, tx_done,
        output full, empty, count, overflow, busy, start_tx, data_in
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Circular byte FIFO feeding uart_ip one frame at a time; first start_tx two edges after a push into an idle empty FIFO.
// Pushes while full are dropped with a one-cycle overflow pulse; the next launch waits for tx_done of the current frame.
module uart_tx_fifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic             i_clock,
    input  logic             i_reset,
    uart_tx_fifo_if.slave    bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    localparam logic [ADDR_W:0]   C_DEPTH   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   C_CNT_ONE = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] C_PTR_ONE = ADDR_W'(1);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic [1:0]        r_state;
    logic [DATA_W-1:0] r_data_in;
    logic              r_overflow;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_drop;
    logic w_launch;

    // Full/empty come from the pre-edge count, so a push into a full FIFO is
    // dropped even when a launch frees a slot on the same edge.
    assign w_full   = (r_count == C_DEPTH);
    assign w_empty  = (r_count == '0);
    assign w_push   = bus.wr_en && !w_full && !bus.flush;
    assign w_drop   = bus.wr_en &&  w_full && !bus.flush;
    assign w_launch = (r_state == S_IDLE) && bus.uart_en && !w_empty && !bus.flush;

    always_ff @(posedge i_clock) begin
        if (w_push && !i_reset) begin
            r_mem[r_wr_ptr] <= bus.wr_data;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= w_drop;
            if (bus.flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
                end
                if (w_launch) begin
                    r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
                end
                case ({w_push, w_launch})
                    2'b10:   r_count <= r_count + C_CNT_ONE;
                    2'b01:   r_count <= r_count - C_CNT_ONE;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // Flush clears the queue only; the frame already handed to uart_ip runs to completion.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state   <= S_IDLE;
            r_data_in <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_launch) begin
                        r_data_in <= r_mem[r_rd_ptr];
                        r_state   <= S_START;
                    end
                end
                S_START: r_state <= S_WAIT;
                S_WAIT: begin
                    if (bus.tx_done) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.full     = w_full;
    assign bus.empty    = w_empty;
    assign bus.count    = r_count;
    assign bus.overflow = r_overflow;
    assign bus.start_tx = (r_state == S_START);
    assign bus.busy     = (r_state == S_START) || (r_state == S_WAIT);
    assign bus.data_in  = r_data_in;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: latency, ordering, overflow/wrap, flush and mid-frame reset.
module tb_uart_tx_fifo;
    logic clk;
    logic rst;
    int   vec_cnt;
    int   err_cnt;
    int   start_cnt;
    logic [7:0] launched [$];

    uart_tx_fifo_if #(.DATA_W(8), .ADDR_W(4)) bus ();

    uart_tx_fifo #(.DEPTH(16), .ADDR_W(4), .DATA_W(8)) dut (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.start_tx === 1'b1) begin
            start_cnt = start_cnt + 1;
            launched.push_back(bus.data_in);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        vec_cnt++; if (bus.empty !== 1'b1) begin $display("FAIL rst_empty got %b exp 1", bus.empty); err_cnt++; end
        vec_cnt++; if (bus.full !== 1'b0) begin $display("FAIL rst_full got %b exp 0", bus.full); err_cnt++; end
        vec_cnt++; if (bus.count !== 5'd0) begin $display("FAIL rst_count got %0d exp 0", bus.count); err_cnt++; end
        vec_cnt++; if (bus.busy !== 1'b0) begin $display("FAIL rst_busy got %b exp 0", bus.busy); err_cnt++; end
        vec_cnt++; if (bus.start_tx !== 1'b0) begin $display("FAIL rst_start got %b exp 0", bus.start_tx); err_cnt++; end
        vec_cnt++; if (bus.data_in !== 8'h00) begin $display("FAIL rst_data got %h exp 00", bus.data_in); err_cnt++; end
        vec_cnt++; if (bus.overflow !== 1'b0) begin $display("FAIL rst_ovf got %b exp 0", bus.overflow); err_cnt++; end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        bus.uart_en = 1'b1;
        bus.wr_en = 1'b1; bus.wr_data = 8'h5A;
        tick();
        bus.wr_en = 1'b0;
        vec_cnt++; if (bus.empty !== 1'b0) begin $display("FAIL single_empty got %b exp 0", bus.empty); err_cnt++; end
        vec_cnt++; if (bus.count !== 5'd1) begin $display("FAIL single_count1 got %0d exp 1", bus.count); err_cnt++; end
        vec_cnt++; if (bus.start_tx !== 1'b0) begin $display("FAIL single_early_start got %b exp 0", bus.start_tx); err_cnt++; end
        tick();
        vec_cnt++; if (bus.start_tx !== 1'b1) begin $display("FAIL single_start got %b exp 1", bus.start_tx); err_cnt++; end
        vec_cnt++; if (bus.data_in !== 8'h5A) begin $display("FAIL single_data got %h exp 5a", bus.data_in); err_cnt++; end
        vec_cnt++; if (bus.count !== 5'd0) begin $display("FAIL single_count0 got %0d exp 0", bus.count); err_cnt++; end
        vec_cnt++; if (bus.busy !== 1'b1) begin $display("FAIL single_busy got %b exp 1", bus.busy); err_cnt++; end
        tick();
        vec_cnt++; if (bus.start_tx !== 1'b0) begin $display("FAIL single_start_width got %b exp 0", bus.start_tx); err_cnt++; end
        vec_cnt++; if (bus.busy !== 1'b1) begin $display("FAIL single_wait_busy got %b exp 1", bus.busy); err_cnt++; end
        repeat (3) tick();
        bus.tx_done = 1'b1; tick(); bus.tx_done = 1'b0;
        vec_cnt++; if (bus.busy !== 1'b0) begin $display("FAIL single_done_busy got %b exp 0", bus.busy); err_cnt++; end
        vec_cnt++; if (bus.data_in !== 8'h5A) begin $display("FAIL single_data_hold got %h exp 5a", bus.data_in); err_cnt++; end
        tick();
        vec_cnt++; if (bus.start_tx !== 1'b0) begin $display("FAIL single_no_relaunch got %b exp 0", bus.start_tx); err_cnt++; end
    endtask

    task automatic test_back_to_back();
        int base;
        base = start_cnt;
        bus.wr_en = 1'b1; bus.wr_data = 8'h01; tick();
        vec_cnt++; if (bus.count !== 5'd1) begin $display("FAIL b2b_count_a got %0d exp 1", bus.count); err_cnt++; end
        bus.wr_data = 8'h02; tick();
        vec_cnt++; if (bus.start_tx !== 1'b1) begin $display("FAIL b2b_start0 got %b exp 1", bus.start_tx); err_cnt++; end
        vec_cnt++; if (bus.data_in !== 8'h01) begin $display("FAIL b2b_data0 got %h exp 01", bus.data_in); err_cnt++; end
        vec_cnt++; if (bus.count !== 5'd1) begin $display("FAIL b2b_count_pushpop got %0d exp 1", bus.count); err_cnt++; end
        bus.wr_data = 8'h03; tick();
        bus.wr_en = 1'b0;
        vec_cnt++; if (bus.count !== 5'd2) begin $display("FAIL b2b_count_b got %0d exp 2", bus.count); err_cnt++; end
        for (int k = 0; k < 3; k++) begin
            repeat (18) tick();
            bus.tx_done = 1'b1; tick(); bus.tx_done = 1'b0;
            vec_cnt++; if (bus.busy !== 1'b0) begin $display("FAIL b2b_idle%0d got %b exp 0", k, bus.busy); err_cnt++; end
            if (k < 2) begin
                tick();
                vec_cnt++; if (bus.start_tx !== 1'b1) begin $display("FAIL b2b_start%0d got %b exp 1", k + 1, bus.start_tx); err_cnt++; end
                vec_cnt++; if (bus.data_in !== 8'(2 + k)) begin $display("FAIL b2b_data%0d got %h exp %h", k + 1, bus.data_in, 8'(2 + k)); err_cnt++; end
                vec_cnt++; if (bus.count !== 5'(1 - k)) begin $display("FAIL b2b_count%0d got %0d exp %0d", k + 1, bus.count, 1 - k); err_cnt++; end
            end
        end
        repeat (3) tick();
        vec_cnt++; if (start_cnt - base !== 3) begin $display("FAIL b2b_launches got %0d exp 3", start_cnt - base); err_cnt++; end
        for (int k = 0; k < 3; k++) begin
            vec_cnt++; if (launched[base + k] !== 8'(1 + k)) begin $display("FAIL b2b_order%0d got %h exp %h", k, launched[base + k], 8'(1 + k)); err_cnt++; end
        end
    endtask

    task automatic test_overflow_wrap();
        bus.uart_en = 1'b0;
        for (int i = 0; i < 16; i++) begin
            bus.wr_en = 1'b1; bus.wr_data = 8'(8'h10 + i); tick();
            vec_cnt++; if (bus.count !== 5'(i + 1)) begin $display("FAIL fill_count%0d got %0d exp %0d", i, bus.count, i + 1); err_cnt++; end
        end
        vec_cnt++; if (bus.full !== 1'b1) begin $display("FAIL fill_full got %b exp 1", bus.full); err_cnt++; end
        vec_cnt++; if (bus.overflow !== 1'b0) begin $display("FAIL fill_ovf_early got %b exp 0", bus.overflow); err_cnt++; end
        bus.wr_data = 8'h20; tick();
        bus.wr_en = 1'b0;
        vec_cnt++; if (bus.overflow !== 1'b1) begin $display("FAIL ovf_pulse got %b exp 1", bus.overflow); err_cnt++; end
        vec_cnt++; if (bus.count !== 5'd16) begin $display("FAIL ovf_count got %0d exp 16", bus.count); err_cnt++; end
        tick();
        vec_cnt++; if (bus.overflow !== 1'b0) begin $display("FAIL ovf_width got %b exp 0", bus.overflow); err_cnt++; end
        vec_cnt++; if (bus.busy !== 1'b0) begin $display("FAIL ovf_no_launch got %b exp 0", bus.busy); err_cnt++; end
    endtask

    task automatic test_full_push_launch();
        int base;
        base = start_cnt;
        bus.uart_en = 1'b1;
        bus.wr_en = 1'b1; bus.wr_data = 8'hAA; tick();
        bus.wr_en = 1'b0;
        vec_cnt++; if (bus.overflow !== 1'b1) begin $display("FAIL fpl_ovf got %b exp 1", bus.overflow); err_cnt++; end
        vec_cnt++; if (bus.start_tx !== 1'b1) begin $display("FAIL fpl_start got %b exp 1", bus.start_tx); err_cnt++; end
        vec_cnt++; if (bus.data_in !== 8'h10) begin $display("FAIL fpl_data got %h exp 10", bus.data_in); err_cnt++; end
        vec_cnt++; if (bus.count !== 5'd15) begin $display("FAIL fpl_count got %0d exp 15", bus.count); err_cnt++; end
        for (int k = 1; k < 16; k++) begin
            repeat (2) tick();
            bus.tx_done = 1'b1; tick(); bus.tx_done = 1'b0;
            tick();
            vec_cnt++; if (bus.data_in !== 8'(8'h10 + k) || bus.start_tx !== 1'b1) begin $display("FAIL drain_data%0d got %h start %b exp %h start 1", k, bus.data_in, bus.start_tx, 8'(8'h10 + k)); err_cnt++; end
            vec_cnt++; if (bus.count !== 5'(15 - k)) begin $display("FAIL drain_count%0d got %0d exp %0d", k, bus.count, 15 - k); err_cnt++; end
        end
        tick();
        bus.tx_done = 1'b1; tick(); bus.tx_done = 1'b0;
        repeat (3) tick();
        vec_cnt++; if (bus.empty !== 1'b1 || bus.busy !== 1'b0) begin $display("FAIL drain_end got empty %b busy %b exp 1 0", bus.empty, bus.busy); err_cnt++; end
        vec_cnt++; if (start_cnt - base !== 16) begin $display("FAIL drain_launches got %0d exp 16", start_cnt - base); err_cnt++; end
    endtask

    task automatic test_flush();
        int base;
        base = start_cnt;
        bus.uart_en = 1'b1;
        bus.wr_en = 1'b1; bus.wr_data = 8'hA1; tick();
        for (int i = 0; i < 4; i++) begin
            bus.wr_data = 8'(8'hB1 + i); tick();
        end
        bus.wr_en = 1'b0;
        vec_cnt++; if (bus.count !== 5'd4) begin $display("FAIL flush_pre_count got %0d exp 4", bus.count); err_cnt++; end
        bus.flush = 1'b1; bus.wr_en = 1'b1; bus.wr_data = 8'hEE; tick();
        bus.flush = 1'b0; bus.wr_en = 1'b0;
        vec_cnt++; if (bus.count !== 5'd0) begin $display("FAIL flush_count got %0d exp 0", bus.count); err_cnt++; end
        vec_cnt++; if (bus.empty !== 1'b1) begin $display("FAIL flush_empty got %b exp 1", bus.empty); err_cnt++; end
        vec_cnt++; if (bus.busy !== 1'b1) begin $display("FAIL flush_busy got %b exp 1", bus.busy); err_cnt++; end
        vec_cnt++; if (bus.data_in !== 8'hA1) begin $display("FAIL flush_data got %h exp a1", bus.data_in); err_cnt++; end
        vec_cnt++; if (bus.overflow !== 1'b0) begin $display("FAIL flush_ovf got %b exp 0", bus.overflow); err_cnt++; end
        tick();
        bus.tx_done = 1'b1; tick(); bus.tx_done = 1'b0;
        repeat (4) tick();
        vec_cnt++; if (bus.busy !== 1'b0) begin $display("FAIL flush_post_busy got %b exp 0", bus.busy); err_cnt++; end
        vec_cnt++; if (start_cnt - base !== 1) begin $display("FAIL flush_launches got %0d exp 1", start_cnt - base); err_cnt++; end
    endtask

    task automatic test_reset_mid();
        int base;
        base = start_cnt;
        bus.uart_en = 1'b1;
        bus.wr_en = 1'b1; bus.wr_data = 8'hC3; tick();
        bus.wr_data = 8'hD4; tick();
        bus.wr_en = 1'b0;
        tick();
        vec_cnt++; if (bus.busy !== 1'b1) begin $display("FAIL rmid_pre_busy got %b exp 1", bus.busy); err_cnt++; end
        rst = 1'b1; tick(); rst = 1'b0;
        vec_cnt++; if (bus.busy !== 1'b0) begin $display("FAIL rmid_busy got %b exp 0", bus.busy); err_cnt++; end
        vec_cnt++; if (bus.data_in !== 8'h00) begin $display("FAIL rmid_data got %h exp 00", bus.data_in); err_cnt++; end
        vec_cnt++; if (bus.count !== 5'd0) begin $display("FAIL rmid_count got %0d exp 0", bus.count); err_cnt++; end
        bus.tx_done = 1'b1; tick(); bus.tx_done = 1'b0;
        repeat (4) tick();
        vec_cnt++; if (start_cnt - base !== 1) begin $display("FAIL rmid_launches got %0d exp 1", start_cnt - base); err_cnt++; end
        vec_cnt++; if (bus.busy !== 1'b0 || bus.empty !== 1'b1) begin $display("FAIL rmid_final got busy %b empty %b exp 0 1", bus.busy, bus.empty); err_cnt++; end
        vec_cnt++; if (bus.data_in !== 8'h00) begin $display("FAIL rmid_final_data got %h exp 00", bus.data_in); err_cnt++; end
    endtask

    initial begin
        vec_cnt = 0;
        err_cnt = 0;
        start_cnt = 0;
        rst = 1'b1;
        bus.uart_en = 1'b0;
        bus.wr_en = 1'b0;
        bus.wr_data = 8'h00;
        bus.flush = 1'b0;
        bus.tx_done = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow_wrap();
        test_full_push_launch();
        test_flush();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
